// File: rtl/riscv_v_pkg.sv
// riscv_v_pkg
//   Shared vector-unit types and sizing constants.
//   - RISCV_V_NUM_BYTES_DATA   : bytes per vector register
//   - RISCV_V_NUM_VALID_OSIZES : one-hot element-size encodings (8/16/32/64 bit)
//   - RISCV_V_VL_WIDTH         : width of an active-element count
//   - riscv_v_result_stage_t   : {valid, rd_addr, data, wr_en} pipeline stage record
package riscv_v_pkg;

    localparam int RISCV_V_NUM_BYTES_DATA   = 16;
    localparam int RISCV_V_NUM_VALID_OSIZES = 4;
    localparam int RISCV_V_VL_WIDTH         = $clog2(RISCV_V_NUM_BYTES_DATA) + 1;
    localparam int RISCV_INSTR_RD_WIDTH     = 5;

    typedef logic [RISCV_INSTR_RD_WIDTH-1:0]       riscv_instr_rd_t;
    typedef logic [RISCV_V_NUM_BYTES_DATA-1:0]     riscv_v_rf_wr_en_t;
    typedef logic [RISCV_V_NUM_VALID_OSIZES-1:0]   osize_vector_t;
    typedef logic [8*RISCV_V_NUM_BYTES_DATA-1:0]   riscv_v_data_t;
    typedef logic [RISCV_V_VL_WIDTH-1:0]           riscv_v_vl_t;

    // Default-width stage record; parameterised units build the same layout
    // locally from their own widths.
    typedef struct packed {
        logic              valid;
        riscv_instr_rd_t   rd_addr;
        riscv_v_data_t     data;
        riscv_v_rf_wr_en_t wr_en;
    } riscv_v_result_stage_t;

endpackage

// File: rtl/riscv_v_byte_en_gen.sv
// riscv_v_byte_en_gen
//   Combinational per-byte register-file write enables from the element
//   mask, vm, element size and vl.
//   Ports:
//     mask         in  NUM_BYTES   element mask, bit j = element j
//     vm           in  1           1 = unmasked operation
//     osize_vector in  NUM_OSIZES  one-hot element size (bit k => 2^k bytes)
//     vl           in  VL_WIDTH    active element count
//     byte_en      out NUM_BYTES   byte write enables
//   A non-one-hot osize_vector yields all-zero enables.
module riscv_v_byte_en_gen
    import riscv_v_pkg::*;
#(
    parameter int NUM_BYTES  = RISCV_V_NUM_BYTES_DATA,
    parameter int NUM_OSIZES = RISCV_V_NUM_VALID_OSIZES,
    parameter int VL_WIDTH   = $clog2(NUM_BYTES) + 1
) (
    input  logic [NUM_BYTES-1:0]  mask,
    input  logic                  vm,
    input  logic [NUM_OSIZES-1:0] osize_vector,
    input  logic [VL_WIDTH-1:0]   vl,
    output logic [NUM_BYTES-1:0]  byte_en
);

    localparam int BIDX_W = (NUM_BYTES  > 1) ? $clog2(NUM_BYTES)  : 1;
    localparam int OIDX_W = (NUM_OSIZES > 1) ? $clog2(NUM_OSIZES) : 1;

    logic osize_ok;

    assign osize_ok = $onehot(osize_vector);

    always_comb begin
        int unsigned j;
        byte_en = '0;
        j       = 0;
        for (int unsigned k = 0; k < NUM_OSIZES; k++) begin
            if (osize_ok && osize_vector[k[OIDX_W-1:0]]) begin
                for (int unsigned b = 0; b < NUM_BYTES; b++) begin
                    // Element index of this byte for element size 2^k bytes.
                    j = b >> k;
                    if ((j < 32'(vl)) && (vm || mask[j[BIDX_W-1:0]])) begin
                        byte_en[b[BIDX_W-1:0]] = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/riscv_v_result_pipe.sv
// riscv_v_result_pipe
//   Vector result pipeline EXE -> MEM -> WB. Captures EXE results with
//   generated byte enables, holds them through MEM and WB, and drives the
//   register-file write buses seen by the bypass network and the RF.
//   Ports:
//     clk, rst            clock, asynchronous active-high reset
//     exe_valid/exe_ready EXE handshake (ready = !mem_valid || !mem_stall)
//     exe_rd_addr, exe_data, exe_mask, exe_vm, exe_osize_vector, exe_vl
//                         EXE result and enable-generation inputs
//     mem_stall           hold the MEM stage
//     flush               kill MEM and the incoming EXE result
//     mem_valid, rf_wr_en_mem, rf_wr_addr_mem, rf_wr_data_mem   MEM stage
//     wb_valid,  rf_wr_en_wb,  rf_wr_addr_wb,  rf_wr_data_wb    WB stage
//     retire_count        WB retirements with nonzero enables (wraps)
module riscv_v_result_pipe
    import riscv_v_pkg::*;
#(
    parameter int NUM_BYTES  = RISCV_V_NUM_BYTES_DATA,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_OSIZES = RISCV_V_NUM_VALID_OSIZES,
    parameter int VL_WIDTH   = $clog2(NUM_BYTES) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     exe_valid,
    output logic                     exe_ready,
    input  logic [ADDR_WIDTH-1:0]    exe_rd_addr,
    input  logic [8*NUM_BYTES-1:0]   exe_data,
    input  logic [NUM_BYTES-1:0]     exe_mask,
    input  logic                     exe_vm,
    input  logic [NUM_OSIZES-1:0]    exe_osize_vector,
    input  logic [VL_WIDTH-1:0]      exe_vl,
    input  logic                     mem_stall,
    input  logic                     flush,
    output logic                     mem_valid,
    output logic [NUM_BYTES-1:0]     rf_wr_en_mem,
    output logic [ADDR_WIDTH-1:0]    rf_wr_addr_mem,
    output logic [8*NUM_BYTES-1:0]   rf_wr_data_mem,
    output logic                     wb_valid,
    output logic [NUM_BYTES-1:0]     rf_wr_en_wb,
    output logic [ADDR_WIDTH-1:0]    rf_wr_addr_wb,
    output logic [8*NUM_BYTES-1:0]   rf_wr_data_wb,
    output logic [31:0]              retire_count
);

    typedef struct packed {
        logic                   valid;
        logic [ADDR_WIDTH-1:0]  rd_addr;
        logic [8*NUM_BYTES-1:0] data;
        logic [NUM_BYTES-1:0]   wr_en;
    } stage_t;

    stage_t               mem_q, mem_d;
    stage_t               wb_q,  wb_d;
    logic [31:0]          retire_q, retire_d;
    logic [NUM_BYTES-1:0] exe_byte_en;
    logic                 accept;
    logic                 mem_to_wb;

    riscv_v_byte_en_gen #(
        .NUM_BYTES  (NUM_BYTES),
        .NUM_OSIZES (NUM_OSIZES),
        .VL_WIDTH   (VL_WIDTH)
    ) u_byte_en_gen (
        .mask         (exe_mask),
        .vm           (exe_vm),
        .osize_vector (exe_osize_vector),
        .vl           (exe_vl),
        .byte_en      (exe_byte_en)
    );

    assign exe_ready = !mem_q.valid || !mem_stall;
    assign accept    = exe_valid && exe_ready && !flush;
    assign mem_to_wb = mem_q.valid && !mem_stall && !flush;

    always_comb begin
        mem_d = mem_q;
        if (flush) begin
            // Address/data are left stale; only valid and enables must clear.
            mem_d.valid = 1'b0;
            mem_d.wr_en = '0;
        end else if (accept) begin
            mem_d.valid   = 1'b1;
            mem_d.rd_addr = exe_rd_addr;
            mem_d.data    = exe_data;
            mem_d.wr_en   = exe_byte_en;
        end else if (mem_stall) begin
            mem_d = mem_q;
        end else begin
            mem_d.valid = 1'b0;
            mem_d.wr_en = '0;
        end
    end

    always_comb begin
        wb_d = wb_q;
        if (mem_to_wb) begin
            wb_d = mem_q;
        end else begin
            // Bubble: WB has no stall, so it never holds a result twice.
            wb_d.valid = 1'b0;
            wb_d.wr_en = '0;
        end
    end

    always_comb begin
        retire_d = retire_q;
        if (wb_q.valid && (|wb_q.wr_en)) begin
            retire_d = retire_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '0;
            wb_q     <= '0;
            retire_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wb_q     <= wb_d;
            retire_q <= retire_d;
        end
    end

    assign mem_valid      = mem_q.valid;
    assign rf_wr_en_mem   = mem_q.wr_en & {NUM_BYTES{mem_q.valid}};
    assign rf_wr_addr_mem = mem_q.rd_addr;
    assign rf_wr_data_mem = mem_q.data;

    assign wb_valid       = wb_q.valid;
    assign rf_wr_en_wb    = wb_q.wr_en & {NUM_BYTES{wb_q.valid}};
    assign rf_wr_addr_wb  = wb_q.rd_addr;
    assign rf_wr_data_wb  = wb_q.data;

    assign retire_count   = retire_q;

    // An offered result with a malformed element size writes nothing.
    a_osize_onehot: assert property (
        @(posedge clk) disable iff (rst)
        (exe_valid && !flush) |-> $onehot(exe_osize_vector)
    ) else $warning("riscv_v_result_pipe: exe_osize_vector is not one-hot");

endmodule

// File: tb/tb_riscv_v_result_pipe.sv
module tb_riscv_v_result_pipe;
    import riscv_v_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         exe_valid;
    logic         exe_ready;
    logic [4:0]   exe_rd_addr;
    logic [127:0] exe_data;
    logic [15:0]  exe_mask;
    logic         exe_vm;
    logic [3:0]   exe_osize_vector;
    logic [4:0]   exe_vl;
    logic         mem_stall;
    logic         flush;
    logic         mem_valid;
    logic [15:0]  rf_wr_en_mem;
    logic [4:0]   rf_wr_addr_mem;
    logic [127:0] rf_wr_data_mem;
    logic         wb_valid;
    logic [15:0]  rf_wr_en_wb;
    logic [4:0]   rf_wr_addr_wb;
    logic [127:0] rf_wr_data_wb;
    logic [31:0]  retire_count;

    int checks   = 0;
    int failures = 0;
    int exp_rc   = 0;

    riscv_v_result_pipe #(
        .NUM_BYTES  (16),
        .ADDR_WIDTH (5),
        .NUM_OSIZES (4),
        .VL_WIDTH   (5)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .exe_valid        (exe_valid),
        .exe_ready        (exe_ready),
        .exe_rd_addr      (exe_rd_addr),
        .exe_data         (exe_data),
        .exe_mask         (exe_mask),
        .exe_vm           (exe_vm),
        .exe_osize_vector (exe_osize_vector),
        .exe_vl           (exe_vl),
        .mem_stall        (mem_stall),
        .flush            (flush),
        .mem_valid        (mem_valid),
        .rf_wr_en_mem     (rf_wr_en_mem),
        .rf_wr_addr_mem   (rf_wr_addr_mem),
        .rf_wr_data_mem   (rf_wr_data_mem),
        .wb_valid         (wb_valid),
        .rf_wr_en_wb      (rf_wr_en_wb),
        .rf_wr_addr_wb    (rf_wr_addr_wb),
        .rf_wr_data_wb    (rf_wr_data_wb),
        .retire_count     (retire_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] a, input logic [127:0] d, input logic [15:0] m,
                         input logic vm, input logic [3:0] os, input logic [4:0] vl);
        exe_valid        = 1'b1;
        exe_rd_addr      = a;
        exe_data         = d;
        exe_mask         = m;
        exe_vm           = vm;
        exe_osize_vector = os;
        exe_vl           = vl;
    endtask

    task automatic idle();
        exe_valid = 1'b0;
    endtask

    // One isolated transaction: check MEM enables, then WB enables, then retire count.
    task automatic en_case(input string tag, input logic [4:0] a, input logic [15:0] m,
                           input logic vm, input logic [3:0] os, input logic [4:0] vl,
                           input logic [15:0] exp_en);
        drive(a, {8{a, 11'h5A5}}, m, vm, os, vl);
        tick();
        idle();
        exe_osize_vector = 4'b0001;
        check({tag, "_mem_valid"}, mem_valid, 1'b1);
        check({tag, "_en_mem"}, rf_wr_en_mem, exp_en);
        tick();
        check({tag, "_wb_valid"}, wb_valid, 1'b1);
        check({tag, "_en_wb"}, rf_wr_en_wb, exp_en);
        check({tag, "_addr_wb"}, rf_wr_addr_wb, a);
        tick();
        if (exp_en != 16'h0) exp_rc++;
        check({tag, "_retire"}, retire_count, exp_rc);
    endtask

    initial begin
        exe_valid        = 1'b0;
        exe_rd_addr      = '0;
        exe_data         = '0;
        exe_mask         = '0;
        exe_vm           = 1'b0;
        exe_osize_vector = 4'b0001;
        exe_vl           = '0;
        mem_stall        = 1'b0;
        flush            = 1'b0;

        #12;
        check("rst_exe_ready", exe_ready, 1'b1);
        check("rst_mem_valid", mem_valid, 1'b0);
        check("rst_wb_valid", wb_valid, 1'b0);
        check("rst_en_mem", rf_wr_en_mem, 16'h0);
        check("rst_en_wb", rf_wr_en_wb, 16'h0);
        check("rst_addr_wb", rf_wr_addr_wb, 5'd0);
        check("rst_data_wb", rf_wr_data_wb, 128'h0);
        check("rst_retire", retire_count, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // 32-bit elements, vl=3, unmasked
        drive(5'd3, 128'h0F0E0D0C0B0A09080706050403020100, 16'h0, 1'b1, 4'b0100, 5'd3);
        tick();
        idle();
        check("t1_mem_valid", mem_valid, 1'b1);
        check("t1_en_mem", rf_wr_en_mem, 16'h0FFF);
        check("t1_addr_mem", rf_wr_addr_mem, 5'd3);
        tick();
        check("t1_wb_valid", wb_valid, 1'b1);
        check("t1_en_wb", rf_wr_en_wb, 16'h0FFF);
        check("t1_addr_wb", rf_wr_addr_wb, 5'd3);
        check("t1_data_wb", rf_wr_data_wb, 128'h0F0E0D0C0B0A09080706050403020100);
        check("t1_mem_empty", mem_valid, 1'b0);
        tick();
        exp_rc = 1;
        check("t1_retire", retire_count, exp_rc);
        check("t1_wb_empty", wb_valid, 1'b0);

        en_case("e8_mask",  5'd7,  16'hA5A5, 1'b0, 4'b0001, 5'd12, 16'h05A5);
        en_case("e16_mask", 5'd8,  16'h0016, 1'b0, 4'b0010, 5'd5,  16'h033C);
        en_case("e64_vlbig",5'd9,  16'h0000, 1'b1, 4'b1000, 5'd20, 16'hFFFF);
        en_case("e8_vlmax", 5'd10, 16'h0000, 1'b1, 4'b0001, 5'd16, 16'hFFFF);
        en_case("os_0000",  5'd11, 16'hFFFF, 1'b1, 4'b0000, 5'd16, 16'h0000);
        en_case("os_0011",  5'd12, 16'hFFFF, 1'b1, 4'b0011, 5'd16, 16'h0000);
        en_case("vl_zero",  5'd13, 16'hFFFF, 1'b1, 4'b0100, 5'd0,  16'h0000);

        // Stream A,B,C with a 2-cycle stall while B sits in MEM
        drive(5'd20, {16{8'hAA}}, 16'h0, 1'b1, 4'b0001, 5'd16);
        tick();
        drive(5'd21, {16{8'hBB}}, 16'h0, 1'b1, 4'b0001, 5'd16);
        tick();
        check("st_wb_A", rf_wr_addr_wb, 5'd20);
        drive(5'd22, {16{8'hCC}}, 16'h0, 1'b1, 4'b0001, 5'd16);
        mem_stall = 1'b1;
        #1;
        check("st_ready_stall0", exe_ready, 1'b0);
        tick();
        check("st_bubble1", rf_wr_en_wb, 16'h0);
        check("st_bubble1_v", wb_valid, 1'b0);
        check("st_hold_B", rf_wr_addr_mem, 5'd21);
        check("st_ready_stall1", exe_ready, 1'b0);
        tick();
        check("st_bubble2", rf_wr_en_wb, 16'h0);
        check("st_hold_B2", rf_wr_addr_mem, 5'd21);
        mem_stall = 1'b0;
        #1;
        check("st_ready_go", exe_ready, 1'b1);
        tick();
        idle();
        check("st_wb_B", rf_wr_addr_wb, 5'd21);
        check("st_wb_B_data", rf_wr_data_wb, {16{8'hBB}});
        check("st_wb_B_en", rf_wr_en_wb, 16'hFFFF);
        check("st_mem_C", rf_wr_addr_mem, 5'd22);
        tick();
        check("st_wb_C", rf_wr_addr_wb, 5'd22);
        check("st_wb_C_data", rf_wr_data_wb, {16{8'hCC}});
        check("st_mem_empty", mem_valid, 1'b0);
        tick();
        check("st_wb_empty", wb_valid, 1'b0);
        exp_rc += 3;
        check("st_retire", retire_count, exp_rc);

        // Flush with A in WB, B in MEM, C offered at EXE
        drive(5'd24, {16{8'h11}}, 16'h0, 1'b1, 4'b0001, 5'd16);
        tick();
        drive(5'd25, {16{8'h22}}, 16'h0, 1'b1, 4'b0001, 5'd16);
        tick();
        drive(5'd26, {16{8'h33}}, 16'h0, 1'b1, 4'b0001, 5'd16);
        flush     = 1'b1;
        mem_stall = 1'b1;
        check("fl_wb_A_valid", wb_valid, 1'b1);
        check("fl_wb_A", rf_wr_addr_wb, 5'd24);
        tick();
        flush     = 1'b0;
        mem_stall = 1'b0;
        idle();
        check("fl_mem_killed", mem_valid, 1'b0);
        check("fl_mem_en", rf_wr_en_mem, 16'h0);
        check("fl_wb_bubble", wb_valid, 1'b0);
        check("fl_wb_en", rf_wr_en_wb, 16'h0);
        tick();
        check("fl_C_dropped", mem_valid, 1'b0);
        check("fl_B_never", wb_valid, 1'b0);
        exp_rc += 1;
        check("fl_retire", retire_count, exp_rc);

        // Asynchronous reset mid-stream
        drive(5'd27, {16{8'h44}}, 16'h0, 1'b1, 4'b0001, 5'd16);
        tick();
        drive(5'd28, {16{8'h55}}, 16'h0, 1'b1, 4'b0001, 5'd16);
        tick();
        #2 rst = 1'b1;
        #1;
        check("ar_mem_valid", mem_valid, 1'b0);
        check("ar_wb_valid", wb_valid, 1'b0);
        check("ar_en_mem", rf_wr_en_mem, 16'h0);
        check("ar_en_wb", rf_wr_en_wb, 16'h0);
        check("ar_retire", retire_count, 32'd0);
        exp_rc = 0;
        idle();
        @(posedge clk);
        #1 rst = 1'b0;
        drive(5'd29, {16{8'h66}}, 16'h0, 1'b1, 4'b0001, 5'd16);
        tick();
        idle();
        check("ar_mem_new", rf_wr_addr_mem, 5'd29);
        tick();
        check("ar_wb_new_valid", wb_valid, 1'b1);
        check("ar_wb_new", rf_wr_addr_wb, 5'd29);
        tick();
        exp_rc = 1;
        check("ar_retire_new", retire_count, exp_rc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/riscv_v_result_pipe.md
Name: riscv_v_result_pipe

Overview:
- Vector result pipeline from the EXE stage into the MEM and WB stages.
- Captures EXE results and generates per-byte RF write enables from element mask, vm, osize and vl.
- Holds results through MEM and WB, and drives the rf_wr_*_mem / rf_wr_*_wb buses consumed by riscv_v_bypass and the vector register file.
- Provides a valid/ready handshake toward EXE, plus stall and flush control.

Parameters:
- NUM_BYTES, default RISCV_V_NUM_BYTES_DATA (16): bytes per vector register.
- ADDR_WIDTH, default 5: register address width (riscv_instr_rd_t).
- NUM_OSIZES, default RISCV_V_NUM_VALID_OSIZES (4): one-hot osize encodings for 8/16/32/64-bit elements.
- VL_WIDTH, default $clog2(NUM_BYTES)+1: width of the vl input.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- exe_valid  in  1  EXE result valid
- exe_ready  out  1  pipe accepts the EXE result this cycle
- exe_rd_addr  in  ADDR_WIDTH  destination register
- exe_data  in  8*NUM_BYTES  result data
- exe_mask  in  NUM_BYTES  element mask, bit j = element j
- exe_vm  in  1  1 = unmasked operation
- exe_osize_vector  in  NUM_OSIZES  one-hot element size
- exe_vl  in  VL_WIDTH  active element count
- mem_stall  in  1  hold the MEM stage
- flush  in  1  kill the MEM stage and the incoming EXE result
- mem_valid  out  1  MEM stage occupied
- rf_wr_en_mem  out  NUM_BYTES  MEM byte enables, gated by mem_valid
- rf_wr_addr_mem  out  ADDR_WIDTH  MEM destination
- rf_wr_data_mem  out  8*NUM_BYTES  MEM data
- wb_valid  out  1  WB stage occupied
- rf_wr_en_wb  out  NUM_BYTES  WB byte enables; these drive the RF write port
- rf_wr_addr_wb  out  ADDR_WIDTH  WB destination
- rf_wr_data_wb  out  8*NUM_BYTES  WB data
- retire_count  out  32  count of WB retirements with a nonzero enable; wraps

Behaviour:
- Reset:
  - All outputs and registers are 0; exe_ready reads 1.
  - Reset mid-operation discards both stages immediately (asynchronous).
- Byte-enable generation (combinational on EXE inputs):
  - Element size E = 2^k bytes, where k is the set bit of exe_osize_vector.
  - Byte b belongs to element j = b/E.
  - en[b] = (j < exe_vl) && (exe_vm || exe_mask[j]).
  - exe_vl >= NUM_BYTES/E enables all elements; exe_vl = 0 gives all-zero enables.
  - exe_osize_vector not one-hot gives all-zero enables; a simulation assertion fires.
- Handshake:
  - exe_ready = !mem_valid || !mem_stall.
  - Accept = exe_valid && exe_ready && !flush.
  - On accept, the MEM registers load addr, data and enables on the next edge, and mem_valid=1.
- MEM stage:
  - mem_stall=1 holds the MEM registers unchanged.
  - If the MEM stage is not stalled and nothing is accepted, mem_valid goes to 0 and the MEM enables clear.
  - A result captured with all-zero enables still occupies the MEM stage (mem_valid=1) but writes nothing.
- MEM to WB:
  - Transfer when mem_valid && !mem_stall && !flush; latency EXE to WB is 2 cycles with no stall.
  - When mem_stall=1 or flush=1, WB loads a bubble: wb_valid=0, rf_wr_en_wb=0; addr/data keep the last value.
  - WB holds for exactly one cycle; there is no WB stall.
- flush:
  - Clears mem_valid and MEM enables next cycle and blocks accept that cycle.
  - WB contents already committed are not affected.
  - flush together with mem_stall: flush wins.
- Enable gating: rf_wr_en_mem/rf_wr_en_wb are always 0 whenever the matching valid is 0. Stale addresses may remain but must never produce a bypass hit.
- retire_count increments on each cycle where wb_valid && |rf_wr_en_wb; it wraps from 0xFFFFFFFF to 0.
- Back-to-back streaming: one result per cycle when mem_stall=0.

Decomposition:
- Shared package riscv_v_pkg additions:
  - riscv_v_vl_t, width VL_WIDTH.
  - A result-stage struct {valid, rd_addr, data, wr_en}, reused by both stage registers.
- Existing types reused: riscv_v_rf_wr_en_t, osize_vector_t, riscv_v_data_t.
- One combinational sub-module, riscv_v_byte_en_gen (mask/vm/osize/vl to byte enables), which other units that need tail/mask enables can share.

Test Plan:
- NUM_BYTES=16, osize=32b (0100), vl=3, vm=1, data=0x00..0F -> after 1 cycle rf_wr_en_mem=0x0FFF; after 2 cycles rf_wr_en_wb=0x0FFF, rf_wr_addr_wb=rd; retire_count=1.
- osize=8b, vm=0, mask=0xA5A5, vl=12 -> rf_wr_en_mem=0x05A5.
- Stream A,B,C one per cycle; assert mem_stall for 2 cycles while B is in MEM:
  - exe_ready=0 during the stall and C is held at EXE.
  - WB shows 2 bubbles (rf_wr_en_wb=0).
  - B then C retire in order, with no loss or duplication.
- flush while B is in MEM and C is at EXE (exe_valid=1) -> B never reaches WB and C is dropped; A, already in WB, still writes.
- osize=0000 or 0011 -> enables 0 and assertion fires; vl=0 -> mem_valid=1 with zero enables and retire_count unchanged.
- Assert rst mid-stream -> all valids/enables 0 asynchronously and retire_count=0; the first accept after release retires 2 cycles later.
